traffic_signal_monitor: RTL and testbench
=========================================

Name: traffic_signal_monitor

Overview:
- Receive-side checker for the two 8-bit ASCII light buses driven by the traffic light controller: main road and county road, each carrying 'G' = 0x47, 'Y' = 0x59 or 'R' = 0x52.
- Decodes each bus to a 2-bit light code and tracks the legal phase sequence GR -> YR -> RG -> RY -> GR.
- Counts dwell time per phase and completed phase cycles.
- Raises a sticky, prioritised fault on any protocol violation; sits beside the controller as a safety monitor.

Parameters:
- DWELL_W, 8: width of the saturating dwell counter.
- CYC_W, 8: width of the wrapping completed-cycle counter.
- YELLOW_MAX, 1: maximum consecutive valid samples in a yellow phase (YR or RY).
- GREEN_MAX, 200: maximum consecutive valid samples in a green phase; used only with MONITOR_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- sample_en  in  1  main_code/county_code valid this cycle
- main_code  in  8  main road ASCII light code
- county_code  in  8  county road ASCII light code
- clear_fault  in  1  clears fault and returns to SYNC
- main_light  out  2  decoded main light: 00 R, 01 Y, 10 G, 11 invalid
- county_light  out  2  decoded county light, same encoding
- in_sync  out  1  monitor is locked to the sequence
- fault  out  1  sticky fault flag
- fault_code  out  3  first fault cause; 0 = none
- dwell  out  DWELL_W  samples spent in current phase
- cycles  out  CYC_W  completed RY->GR transitions

Behaviour:
- Reset values: all outputs 0, except main_light = county_light = 2'b11. State = SYNC.
- All outputs registered; each updates on the clk edge that captures a sample_en = 1 cycle, so latency is 1 cycle.
- Cycles with sample_en = 0 change nothing.
- Decode: any byte other than 0x47/0x59/0x52 decodes to 11 (invalid).
- Pair classification uses the decoded (main, county) lights:
  - legal: GR, YR, RG, RY
  - CONFLICT: neither road R
  - ALL_RED: RR
- Fault codes, highest priority first:
  - 1 BAD_CODE: either light invalid
  - 2 CONFLICT
  - 3 ALL_RED
  - 4 BAD_TRANS: legal pair, not the same or next phase
  - 5 YELLOW_LONG: yellow dwell would exceed YELLOW_MAX
  - 6 GREEN_LONG: optional, see below
- FSM states: SYNC, TRACK, FAULT.
- SYNC:
  - First sample holding a legal pair -> TRACK; phase := that pair; dwell := 1; in_sync := 1.
  - Codes 1-3 -> FAULT.
- TRACK:
  - Same pair: dwell +1, saturating at all-ones.
  - Next pair in sequence: dwell := 1.
  - RY -> GR additionally increments cycles (wraps at 2^CYC_W).
  - Any fault condition -> FAULT.
- FAULT:
  - fault = 1; fault_code latched on entry; in_sync = 0.
  - Later samples still update main_light/county_light but do not change fault_code, dwell or cycles.
  - Stays until clear_fault.
- clear_fault = 1: next state SYNC, fault := 0, fault_code := 0, dwell := 0; cycles keeps its value.
  - It takes priority over a sample arriving the same cycle; that sample's fault/sync evaluation is discarded.
  - Decoded lights still update from that sample.
- Yellow check: the fault triggers on the sample that would make yellow dwell YELLOW_MAX + 1.
  - With YELLOW_MAX = 1, a repeated YR or RY sample is a fault.
- Reset mid-operation: immediate return to reset values.

Optional Feature:
- MONITOR_TIMEOUT_EN defined: in TRACK, a GR or RG sample that would make dwell GREEN_MAX + 1 -> FAULT with code 6 (GREEN_LONG). Requires DWELL_W wide enough to hold GREEN_MAX + 1.
- Not defined: no green limit; GREEN_MAX is ignored; code 6 is never produced.

Decomposition:
- Package traffic_pkg holds:
  - ASCII constants: CH_G = 8'h47, CH_Y = 8'h59, CH_R = 8'h52
  - light typedef: 2-bit R/Y/G/INV
  - phase typedef: GR/YR/RG/RY
  - monitor state typedef: SYNC/TRACK/FAULT
  - fault_code localparams 0-6
- One sub-module, traffic_light_decode: combinational, 8-bit ASCII -> 2-bit light. Instantiate twice.

Test Plan:
- Reset, then samples GR, GR, YR, RG, RG, RY, GR -> in_sync = 1 after the first; cycles = 1 after the last; fault = 0; dwell = 1 after the last.
- In TRACK at phase GR, sample main = 0x41 ('A') -> fault = 1, fault_code = 1, main_light = 11.
- In TRACK, sample GG (0x47/0x47) -> fault_code = 2; then assert clear_fault -> fault = 0, state SYNC.
- Samples GR then RG (yellow skipped) -> fault_code = 4 on the RG sample; further samples leave fault_code at 4.
- With YELLOW_MAX = 1, samples GR, YR, YR -> fault_code = 5 on the second YR.
- With MONITOR_TIMEOUT_EN and GREEN_MAX = 3, four consecutive GR samples -> fault_code = 6 on the 4th. Without the macro, 300 GR samples -> dwell saturates at 255, no fault.

Source files
------------

// File: rtl/traffic_signal_monitor_pkg.sv
// Shared types and constants for the traffic light bus monitor.
// Light codes, phase ordering, monitor states and fault causes.
package traffic_pkg;

   localparam logic [7:0] CH_G = 8'h47;
   localparam logic [7:0] CH_Y = 8'h59;
   localparam logic [7:0] CH_R = 8'h52;

   typedef enum logic [1:0] {
      L_R   = 2'b00,
      L_Y   = 2'b01,
      L_G   = 2'b10,
      L_INV = 2'b11
   } light_t;

   typedef enum logic [1:0] {
      PH_GR = 2'd0,
      PH_YR = 2'd1,
      PH_RG = 2'd2,
      PH_RY = 2'd3
   } phase_t;

   typedef enum logic [1:0] {
      ST_SYNC  = 2'd0,
      ST_TRACK = 2'd1,
      ST_FAULT = 2'd2
   } mon_state_t;

   localparam logic [2:0] FC_NONE        = 3'd0;
   localparam logic [2:0] FC_BAD_CODE    = 3'd1;
   localparam logic [2:0] FC_CONFLICT    = 3'd2;
   localparam logic [2:0] FC_ALL_RED     = 3'd3;
   localparam logic [2:0] FC_BAD_TRANS   = 3'd4;
   localparam logic [2:0] FC_YELLOW_LONG = 3'd5;
   localparam logic [2:0] FC_GREEN_LONG  = 3'd6;

   // Phase encoding is chosen so the legal successor is simply +1 mod 4.
   function automatic phase_t next_phase(input phase_t p);
      return phase_t'(p + 2'd1);
   endfunction

endpackage

// File: rtl/traffic_signal_monitor_decode.sv
// ASCII light byte to 2-bit light code.
// Unknown bytes decode to the invalid code.
module traffic_light_decode
   import traffic_pkg::*;
(
   input  logic [7:0] i_code,
   output logic [1:0] o_light
);

   always_comb begin
      o_light = L_INV;
      unique case (i_code)
         CH_G:    o_light = L_G;
         CH_Y:    o_light = L_Y;
         CH_R:    o_light = L_R;
         default: o_light = L_INV;
      endcase
   end

endmodule

// File: rtl/traffic_signal_monitor.sv
// Safety monitor for the main/county light buses of the controller.
// Build option: MONITOR_TIMEOUT_EN enables the green dwell limit.
module traffic_signal_monitor
   import traffic_pkg::*;
#(
   parameter int DWELL_W    = 8,
   parameter int CYC_W      = 8,
   parameter int YELLOW_MAX = 1,
   parameter int GREEN_MAX  = 200
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               sample_en,
   input  logic [7:0]         main_code,
   input  logic [7:0]         county_code,
   input  logic               clear_fault,
   output logic [1:0]         main_light,
   output logic [1:0]         county_light,
   output logic               in_sync,
   output logic               fault,
   output logic [2:0]         fault_code,
   output logic [DWELL_W-1:0] dwell,
   output logic [CYC_W-1:0]   cycles
);

   localparam logic [DWELL_W-1:0] LP_YMAX = DWELL_W'(YELLOW_MAX);

   logic [1:0]         w_main;
   logic [1:0]         w_county;
   logic [2:0]         w_pcode;
   logic [2:0]         w_tcode;
   phase_t             w_phase;
   logic               w_same;
   logic               w_next;
   logic               w_yellow;
   logic               w_green_hit;
   logic [DWELL_W-1:0] w_dwell_inc;

   logic [1:0]         r_main;
   logic [1:0]         r_county;
   mon_state_t         r_state;
   phase_t             r_phase;
   logic               r_sync;
   logic               r_fault;
   logic [2:0]         r_fcode;
   logic [DWELL_W-1:0] r_dwell;
   logic [CYC_W-1:0]   r_cycles;

   traffic_light_decode u_dec_main (
      .i_code  (main_code),
      .o_light (w_main)
   );

   traffic_light_decode u_dec_county (
      .i_code  (county_code),
      .o_light (w_county)
   );

   // Pair-level faults outrank anything that depends on history.
   always_comb begin
      w_pcode = FC_NONE;
      w_phase = PH_GR;
      if (w_main == L_INV || w_county == L_INV)
         w_pcode = FC_BAD_CODE;
      else if (w_main != L_R && w_county != L_R)
         w_pcode = FC_CONFLICT;
      else if (w_main == L_R && w_county == L_R)
         w_pcode = FC_ALL_RED;
      else if (w_main == L_G)
         w_phase = PH_GR;
      else if (w_main == L_Y)
         w_phase = PH_YR;
      else if (w_county == L_G)
         w_phase = PH_RG;
      else
         w_phase = PH_RY;
   end

   assign w_same      = (w_phase == r_phase);
   assign w_next      = (w_phase == next_phase(r_phase));
   assign w_yellow    = r_phase[0];
   assign w_dwell_inc = (&r_dwell) ? r_dwell : r_dwell + 1'b1;

`ifdef MONITOR_TIMEOUT_EN
   localparam logic [DWELL_W-1:0] LP_GMAX = DWELL_W'(GREEN_MAX);
   assign w_green_hit = !w_yellow && (r_dwell >= LP_GMAX);
`else
   assign w_green_hit = 1'b0;
`endif

   always_comb begin
      w_tcode = w_pcode;
      if (w_pcode == FC_NONE) begin
         if (!w_same && !w_next)
            w_tcode = FC_BAD_TRANS;
         else if (w_same && w_yellow && r_dwell >= LP_YMAX)
            w_tcode = FC_YELLOW_LONG;
         else if (w_same && w_green_hit)
            w_tcode = FC_GREEN_LONG;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_main   <= L_INV;
         r_county <= L_INV;
         r_state  <= ST_SYNC;
         r_phase  <= PH_GR;
         r_sync   <= 1'b0;
         r_fault  <= 1'b0;
         r_fcode  <= FC_NONE;
         r_dwell  <= '0;
         r_cycles <= '0;
      end else if (clear_fault) begin
         if (sample_en) begin
            r_main   <= w_main;
            r_county <= w_county;
         end
         r_state <= ST_SYNC;
         r_sync  <= 1'b0;
         r_fault <= 1'b0;
         r_fcode <= FC_NONE;
         r_dwell <= '0;
      end else if (sample_en) begin
         r_main   <= w_main;
         r_county <= w_county;
         unique case (r_state)
            ST_SYNC: begin
               if (w_pcode != FC_NONE) begin
                  r_state <= ST_FAULT;
                  r_fault <= 1'b1;
                  r_fcode <= w_pcode;
               end else begin
                  r_state <= ST_TRACK;
                  r_phase <= w_phase;
                  r_dwell <= DWELL_W'(1);
                  r_sync  <= 1'b1;
               end
            end
            ST_TRACK: begin
               if (w_tcode != FC_NONE) begin
                  r_state <= ST_FAULT;
                  r_fault <= 1'b1;
                  r_fcode <= w_tcode;
                  r_sync  <= 1'b0;
               end else if (w_same) begin
                  r_dwell <= w_dwell_inc;
               end else begin
                  r_phase <= w_phase;
                  r_dwell <= DWELL_W'(1);
                  if (r_phase == PH_RY)
                     r_cycles <= r_cycles + 1'b1;
               end
            end
            ST_FAULT: ;
            default:  r_state <= ST_SYNC;
         endcase
      end
   end

   assign main_light   = r_main;
   assign county_light = r_county;
   assign in_sync      = r_sync;
   assign fault        = r_fault;
   assign fault_code   = r_fcode;
   assign dwell        = r_dwell;
   assign cycles       = r_cycles;

endmodule

// File: tb/tb_traffic_signal_monitor.sv
// Scoreboard bench for traffic_signal_monitor.
// Define MONITOR_TIMEOUT_EN to exercise the green limit with GREEN_MAX = 3.
module tb_traffic_signal_monitor;

`ifdef MONITOR_TIMEOUT_EN
   localparam int TB_GMAX = 3;
`else
   localparam int TB_GMAX = 200;
`endif
   localparam int YMAX = 1;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       sample_en = 1'b0;
   logic [7:0] main_code = 8'h00;
   logic [7:0] county_code = 8'h00;
   logic       clear_fault = 1'b0;
   logic [1:0] main_light;
   logic [1:0] county_light;
   logic       in_sync;
   logic       fault;
   logic [2:0] fault_code;
   logic [7:0] dwell;
   logic [7:0] cycles;

   traffic_signal_monitor #(
      .DWELL_W    (8),
      .CYC_W      (8),
      .YELLOW_MAX (YMAX),
      .GREEN_MAX  (TB_GMAX)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .sample_en    (sample_en),
      .main_code    (main_code),
      .county_code  (county_code),
      .clear_fault  (clear_fault),
      .main_light   (main_light),
      .county_light (county_light),
      .in_sync      (in_sync),
      .fault        (fault),
      .fault_code   (fault_code),
      .dwell        (dwell),
      .cycles       (cycles)
   );

   always #5 clk = ~clk;

   typedef struct {
      int ml;
      int cl;
      int sync;
      int flt;
      int code;
      int dw;
      int cyc;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail = 0;

   int m_ml, m_cl, m_st, m_ph, m_sync, m_fault, m_code, m_dwell, m_cyc;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int dec(input logic [7:0] x);
      case (x)
         8'h47:   return 2;
         8'h59:   return 1;
         8'h52:   return 0;
         default: return 3;
      endcase
   endfunction

   task automatic model_reset();
      m_ml = 3; m_cl = 3; m_st = 0; m_ph = 0;
      m_sync = 0; m_fault = 0; m_code = 0; m_dwell = 0; m_cyc = 0;
   endtask

   task automatic model(input logic en, input logic [7:0] mc,
                        input logic [7:0] cc, input logic clr);
      int a, b, code, p;
      a = dec(mc);
      b = dec(cc);
      if (en) begin
         m_ml = a;
         m_cl = b;
      end
      if (clr) begin
         m_st = 0; m_fault = 0; m_code = 0; m_dwell = 0; m_sync = 0;
         return;
      end
      if (!en || m_st == 2) return;
      code = 0;
      p = 0;
      if (a == 3 || b == 3) code = 1;
      else if (a != 0 && b != 0) code = 2;
      else if (a == 0 && b == 0) code = 3;
      else p = (a == 2) ? 0 : (a == 1) ? 1 : (b == 2) ? 2 : 3;
      if (code == 0 && m_st == 1) begin
         if (p == m_ph) begin
            if ((p % 2) == 1 && m_dwell + 1 > YMAX) code = 5;
`ifdef MONITOR_TIMEOUT_EN
            if (code == 0 && (p % 2) == 0 && m_dwell + 1 > TB_GMAX) code = 6;
`endif
            if (code == 0) m_dwell = (m_dwell < 255) ? m_dwell + 1 : 255;
         end else if (p == (m_ph + 1) % 4) begin
            if (m_ph == 3) m_cyc = (m_cyc + 1) % 256;
            m_ph = p;
            m_dwell = 1;
         end else begin
            code = 4;
         end
      end else if (code == 0) begin
         m_st = 1; m_ph = p; m_dwell = 1; m_sync = 1;
      end
      if (code != 0) begin
         m_st = 2; m_fault = 1; m_code = code; m_sync = 0;
      end
   endtask

   task automatic push_exp();
      exp_t e;
      e.ml = m_ml; e.cl = m_cl; e.sync = m_sync; e.flt = m_fault;
      e.code = m_code; e.dw = m_dwell; e.cyc = m_cyc;
      sb.push_back(e);
   endtask

   task automatic compare(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         check({tag, " sb_empty"}, 1, 0);
         return;
      end
      e = sb.pop_front();
      check({tag, " main_light"}, int'(main_light), e.ml);
      check({tag, " county_light"}, int'(county_light), e.cl);
      check({tag, " in_sync"}, int'(in_sync), e.sync);
      check({tag, " fault"}, int'(fault), e.flt);
      check({tag, " fault_code"}, int'(fault_code), e.code);
      check({tag, " dwell"}, int'(dwell), e.dw);
      check({tag, " cycles"}, int'(cycles), e.cyc);
   endtask

   task automatic send(input string tag, input logic en, input logic [7:0] mc,
                       input logic [7:0] cc, input logic clr);
      @(negedge clk);
      sample_en = en;
      main_code = mc;
      county_code = cc;
      clear_fault = clr;
      model(en, mc, cc, clr);
      push_exp();
      @(posedge clk);
      #1;
      compare(tag);
      sample_en = 1'b0;
      clear_fault = 1'b0;
   endtask

   localparam logic [7:0] G = 8'h47, Y = 8'h59, R = 8'h52, A = 8'h41;

   initial begin
      model_reset();
      #23;
      push_exp();
      compare("reset");
      @(negedge clk);
      reset = 1'b0;

      send("s1_gr", 1, G, R, 0);
      send("s2_gr", 1, G, R, 0);
      send("s3_yr", 1, Y, R, 0);
      send("s4_rg", 1, R, G, 0);
      send("s5_rg", 1, R, G, 0);
      send("s6_ry", 1, R, Y, 0);
      send("s7_gr", 1, G, R, 0);
      send("idle", 0, A, A, 0);

      send("bad_code", 1, A, R, 0);
      send("flt_hold", 1, G, R, 0);
      send("clr_gr", 1, G, R, 1);

      send("c_gr", 1, G, R, 0);
      send("conflict", 1, G, G, 0);
      send("clr2", 1, R, R, 1);

      send("t_gr", 1, G, R, 0);
      send("skip_rg", 1, R, G, 0);
      send("hold_yr", 1, Y, R, 0);
      send("hold_bad", 1, A, A, 0);
      send("clr3", 1, G, R, 1);

      send("y_gr", 1, G, R, 0);
      send("y_yr", 1, Y, R, 0);
      send("y_yr2", 1, Y, R, 0);
      send("clr4", 1, G, R, 1);

      send("allred", 1, R, R, 0);
      send("clr5", 1, R, G, 1);

`ifdef MONITOR_TIMEOUT_EN
      for (int i = 0; i < 4; i++) send("green_to", 1, G, R, 0);
`else
      for (int i = 0; i < 300; i++) send("green_sat", 1, G, R, 0);
`endif
      send("clr6", 1, R, Y, 1);
      send("ry_start", 1, R, Y, 0);
      send("ry_gr", 1, G, R, 0);

      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      push_exp();
      compare("mid_reset");
      @(negedge clk);
      reset = 1'b0;
      send("post_rst", 1, Y, R, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
